// File: rtl/demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_pkg                                                          |
// | Shared constants and channel state type for the 1x4 stream demux.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package demux_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_t;

endpackage
`default_nettype wire

// File: rtl/demux_chan_reg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_chan_reg                                                     |
// | One-entry holding register for a single demux output channel.     |
// | Optional per-channel drain counter when DEMUX_STATS_EN is defined. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module demux_chan_reg
    import demux_pkg::*;
#(
    parameter int DATA_W = 8
`ifdef DEMUX_STATS_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [DATA_W-1:0] in_data,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid
`ifdef DEMUX_STATS_EN
    ,
    output logic [CNT_W-1:0]  beat_cnt
`endif
);

    chan_state_t       r_state;
    logic [DATA_W-1:0] r_data;
    logic              w_drain;

    assign out_valid = (r_state == FULL);
    assign out_data  = r_data;
    assign w_drain   = out_valid & out_ready;

    // A load always wins over a drain, so FULL persists on drain+load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
            r_data  <= '0;
        end else begin
            case (r_state)
                EMPTY:   if (load) r_state <= FULL;
                FULL:    if (w_drain && !load) r_state <= EMPTY;
                default: r_state <= EMPTY;
            endcase
            if (load) r_data <= in_data;
        end
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_drain) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign beat_cnt = r_cnt;
`endif

endmodule
`default_nettype wire

// File: rtl/demux_1x4_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | demux_1x4_stream                                                   |
// | Registered 1-to-4 valid/ready stream demultiplexer.                |
// | Define DEMUX_STATS_EN to add per-channel delivered-beat counters.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module demux_1x4_stream
    import demux_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [SEL_W-1:0]         in_sel,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [NUM_CH*DATA_W-1:0] out_data,
    output logic [NUM_CH-1:0]        out_valid,
    input  logic [NUM_CH-1:0]        out_ready
`ifdef DEMUX_STATS_EN
    ,
    output logic [NUM_CH*CNT_W-1:0]  beat_cnt
`endif
);

    logic [NUM_CH-1:0] w_load;

    // Only the selected channel can stall the producer.
    assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];

    for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
        assign w_load[k] = in_valid & in_ready & (in_sel == SEL_W'(k));

        demux_chan_reg #(
            .DATA_W (DATA_W)
`ifdef DEMUX_STATS_EN
            ,
            .CNT_W  (CNT_W)
`endif
        ) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .load      (w_load[k]),
            .in_data   (in_data),
            .out_ready (out_ready[k]),
            .out_data  (out_data[k*DATA_W +: DATA_W]),
            .out_valid (out_valid[k])
`ifdef DEMUX_STATS_EN
            ,
            .beat_cnt  (beat_cnt[k*CNT_W +: CNT_W])
`endif
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_demux_1x4_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_demux_1x4_stream                                                |
// | Directed and random scoreboard bench for demux_1x4_stream.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_demux_1x4_stream;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int NCH    = 4;

    logic                    clk;
    logic                    rst_n;
    logic [DATA_W-1:0]       in_data;
    logic [1:0]              in_sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [NCH*DATA_W-1:0]   out_data;
    logic [NCH-1:0]          out_valid;
    logic [NCH-1:0]          out_ready;
`ifdef DEMUX_STATS_EN
    logic [NCH*CNT_W-1:0]    beat_cnt;
`endif

    demux_1x4_stream #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef DEMUX_STATS_EN
        ,
        .beat_cnt  (beat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int              n_cmp = 0;
    int              n_err = 0;
    logic [DATA_W-1:0] sbq [NCH][$];
    logic [DATA_W-1:0] last_data [NCH];
    logic [CNT_W-1:0]  exp_cnt [NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < NCH; k++) begin
            sbq[k].delete();
            last_data[k] = '0;
            exp_cnt[k]   = '0;
        end
    endtask

    // Compare DUT against the scoreboard at the falling edge, then apply
    // the transfers the coming rising edge will perform.
    task automatic step();
        logic exp_rdy;
        logic [NCH-1:0] exp_v;
        @(negedge clk);
        for (int k = 0; k < NCH; k++) begin
            exp_v[k] = (sbq[k].size() != 0);
            chk($sformatf("out_valid[%0d]", k), 32'(out_valid[k]), 32'(exp_v[k]));
            chk($sformatf("out_data[%0d]", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(last_data[k]));
`ifdef DEMUX_STATS_EN
            chk($sformatf("beat_cnt[%0d]", k), 32'(beat_cnt[k*CNT_W +: CNT_W]), 32'(exp_cnt[k]));
`endif
        end
        exp_rdy = !exp_v[in_sel] || out_ready[in_sel];
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        if (rst_n) begin
            for (int k = 0; k < NCH; k++) begin
                if (exp_v[k] && out_ready[k]) begin
                    void'(sbq[k].pop_front());
                    exp_cnt[k] = exp_cnt[k] + 1'b1;
                end
            end
            if (in_valid && exp_rdy) begin
                sbq[in_sel].push_back(in_data);
                last_data[in_sel] = in_data;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] s, input logic [DATA_W-1:0] d,
                         input logic [NCH-1:0] rdy);
        in_valid  = v;
        in_sel    = s;
        in_data   = d;
        out_ready = rdy;
    endtask

    task automatic do_reset();
        drive(1'b0, 2'd0, '0, 4'b0000);
        rst_n = 1'b0;
        model_clear();
        repeat (2) step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 2'd0, '0, 4'b0000);
        model_clear();
        repeat (2) step();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_out_data", out_data, 32'h0);
        rst_n = 1'b1;
        step();

        // Routing: one beat per channel, back-to-back, consumers ready.
        for (int k = 0; k < NCH; k++) begin
            drive(1'b1, 2'(k), 8'hA0 + 8'(k), 4'b1111);
            step();
            chk($sformatf("route_valid_%0d", k), 32'(out_valid), 32'(1 << k));
            chk($sformatf("route_data_%0d", k), 32'(out_data[k*DATA_W +: DATA_W]), 32'(8'hA0 + 8'(k)));
        end
        drive(1'b0, 2'd0, '0, 4'b1111);
        step();

        // Backpressure on channel 1, channel 3 still accepts.
        drive(1'b1, 2'd1, 8'h11, 4'b1101);
        step();
        drive(1'b1, 2'd1, 8'h22, 4'b1101);
        #1;
        chk("bp_in_ready_ch1", 32'(in_ready), 32'h0);
        step();
        chk("bp_hold_ch1", 32'(out_data[1*DATA_W +: DATA_W]), 32'h11);
        drive(1'b1, 2'd3, 8'h33, 4'b0101);
        #1;
        chk("bp_in_ready_ch3", 32'(in_ready), 32'h1);
        step();
        chk("bp_ch3_data", 32'(out_data[3*DATA_W +: DATA_W]), 32'h33);
        chk("bp_ch1_still", 32'(out_data[1*DATA_W +: DATA_W]), 32'h11);
        drive(1'b0, 2'd0, '0, 4'b1111);
        repeat (2) step();

        // Drain and load on channel 0 in the same cycle.
        drive(1'b1, 2'd0, 8'h55, 4'b0000);
        step();
        drive(1'b1, 2'd0, 8'h66, 4'b0001);
        #1;
        chk("dl_in_ready", 32'(in_ready), 32'h1);
        chk("dl_old_data", 32'(out_data[7:0]), 32'h55);
        step();
        drive(1'b0, 2'd0, '0, 4'b0000);
        #1;
        chk("dl_new_valid", 32'(out_valid[0]), 32'h1);
        chk("dl_new_data", 32'(out_data[7:0]), 32'h66);
        step();

        // Asynchronous reset with channel 2 full.
        drive(1'b1, 2'd2, 8'h77, 4'b0000);
        step();
        drive(1'b0, 2'd0, '0, 4'b0000);
        chk("pre_rst_ch2_full", 32'(out_valid[2]), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'h0);
        chk("async_rst_data", out_data, 32'h0);
`ifdef DEMUX_STATS_EN
        chk("async_rst_cnt", beat_cnt, 32'h0);
`endif
        model_clear();
        step();
        rst_n = 1'b1;
        step();

`ifdef DEMUX_STATS_EN
        // Counter wrap: 17 drains on channel 3 with a 4-bit counter.
        do_reset();
        for (int i = 0; i < 17; i++) begin
            drive(1'b1, 2'd3, 8'(i), 4'b1000);
            step();
        end
        drive(1'b0, 2'd0, '0, 4'b1000);
        step();
        chk("stats_wrap_ch3", 32'(beat_cnt[3*CNT_W +: CNT_W]), 32'h1);
        chk("stats_other", 32'(beat_cnt[3*CNT_W-1:0]), 32'h0);
`endif

        // Random traffic against the scoreboard.
        do_reset();
        for (int i = 0; i < 10000; i++) begin
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
                  8'($urandom), 4'($urandom));
            step();
        end
        drive(1'b0, 2'd0, '0, 4'b1111);
        repeat (2) step();
        chk("rand_drained", 32'(out_valid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
